uart_prog_loader: RTL

//  Serial program loader: receives a framed 8N1 UART image and writes it into the

---
 rtl/uart_prog_loader_pkg.sv | 18 +
 rtl/uart_prog_loader_if.sv | 11 +
 rtl/uart_prog_loader_uart_rx.sv | 91 +++++++++
 rtl/uart_prog_loader.sv | 128 ++++++++++++
 4 files changed

// File: rtl/uart_prog_loader_pkg.sv
// Shared types and constants for the serial program loader.
// Build option: LOADER_CHECKSUM_EN enables the trailing checksum byte.
package loader_pkg;

   typedef enum logic [2:0] {IDLE, LEN, DATA, CSUM, FIN} ld_state_t;

   localparam logic [7:0] SYNC_BYTE = 8'hA5;

   function automatic int unsigned baud_div(input int unsigned clk_hz, input int unsigned baud);
      return clk_hz / baud;
   endfunction

   // Frame checksum: sync byte, length byte and all data bytes summed mod 256.
   function automatic logic [7:0] frame_csum(input logic [7:0] len, input logic [7:0] sum);
      return SYNC_BYTE + len + sum;
   endfunction

endpackage

// File: rtl/uart_prog_loader_if.sv
// RAM write-port bundle driven by the program loader.
interface uart_prog_loader_if #(
   parameter int unsigned ADDR_W = 8
);
   logic              we;
   logic [ADDR_W-1:0] w_addr;
   logic [7:0]        w_data;

   modport master (output we, output w_addr, output w_data);
   modport slave  (input  we, input  w_addr, input  w_data);
endinterface

// File: rtl/uart_prog_loader_uart_rx.sv
// 8N1 UART receiver: 2-FF synchronizer, mid-bit sampling, one-cycle byte and framing-error strobes.
module uart_rx
   import loader_pkg::*;
#(
   parameter int unsigned CLK_HZ = 27_000_000,
   parameter int unsigned BAUD   = 115_200
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] data,
   output logic       valid,
   output logic       frame_err
);

   localparam int unsigned DIV   = baud_div(CLK_HZ, BAUD);
   localparam int unsigned CNT_W = $clog2(DIV);
   localparam logic [CNT_W-1:0] HALF = CNT_W'(DIV / 2 - 1);
   localparam logic [CNT_W-1:0] FULL = CNT_W'(DIV - 1);

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_BITS, RX_STOP} rx_state_t;

   rx_state_t        state;
   logic             rx_meta, rx_sync, rx_prev;
   logic [CNT_W-1:0] cnt;
   logic [2:0]       bit_idx;
   logic [7:0]       shreg;

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_meta   <= 1'b1;
         rx_sync   <= 1'b1;
         rx_prev   <= 1'b1;
         state     <= RX_IDLE;
         cnt       <= '0;
         bit_idx   <= '0;
         shreg     <= '0;
         data      <= '0;
         valid     <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         rx_meta   <= rx;
         rx_sync   <= rx_meta;
         rx_prev   <= rx_sync;
         valid     <= 1'b0;
         frame_err <= 1'b0;
         unique case (state)
            RX_IDLE: begin
               cnt <= '0;
               if (rx_prev && !rx_sync) state <= RX_START;
            end
            RX_START: begin
               // A line that is high again at half a bit was a glitch, not a start bit.
               if (cnt == HALF) begin
                  cnt     <= '0;
                  bit_idx <= '0;
                  state   <= rx_sync ? RX_IDLE : RX_BITS;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            RX_BITS: begin
               if (cnt == FULL) begin
                  cnt     <= '0;
                  shreg   <= {rx_sync, shreg[7:1]};
                  bit_idx <= bit_idx + 3'd1;
                  if (bit_idx == 3'd7) state <= RX_STOP;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            RX_STOP: begin
               if (cnt == FULL) begin
                  cnt   <= '0;
                  state <= RX_IDLE;
                  if (rx_sync) begin
                     data  <= shreg;
                     valid <= 1'b1;
                  end else begin
                     frame_err <= 1'b1;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= RX_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/uart_prog_loader.sv
// Serial program loader: receives a SYNC/LEN/DATA[/CSUM] UART frame and writes it into program RAM,
// holding the CPU in reset while a frame is in progress. Option: LOADER_CHECKSUM_EN.
module uart_prog_loader
   import loader_pkg::*;
#(
   parameter int unsigned CLK_HZ = 27_000_000,
   parameter int unsigned BAUD   = 115_200,
   parameter int unsigned ADDR_W = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               uart_rx,
   uart_prog_loader_if.master ram,
   output logic               cpu_hold,
   output logic               done,
   output logic               err
);

   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ferr;

   uart_rx #(
      .CLK_HZ (CLK_HZ),
      .BAUD   (BAUD)
   ) u_rx (
      .clk       (clk),
      .rst       (rst),
      .rx        (uart_rx),
      .data      (rx_data),
      .valid     (rx_valid),
      .frame_err (rx_ferr)
   );

   ld_state_t         state;
   logic [7:0]        len;
   logic [7:0]        idx;
   logic [7:0]        sum;
   logic              we;
   logic [ADDR_W-1:0] w_addr;
   logic [7:0]        w_data;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         len      <= '0;
         idx      <= '0;
         sum      <= '0;
         we       <= 1'b0;
         w_addr   <= '0;
         w_data   <= '0;
         cpu_hold <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
      end else begin
         we <= 1'b0;
         // Address advances after each write; wraps naturally at 2**ADDR_W.
         if (we) w_addr <= w_addr + 1'b1;
         if (rx_ferr && state != IDLE) begin
            err      <= 1'b1;
            done     <= 1'b0;
            cpu_hold <= 1'b0;
            state    <= IDLE;
         end else begin
            unique case (state)
               IDLE: begin
                  if (rx_valid && rx_data == SYNC_BYTE) begin
                     cpu_hold <= 1'b1;
                     done     <= 1'b0;
                     err      <= 1'b0;
                     state    <= LEN;
                  end
               end
               LEN: begin
                  if (rx_valid) begin
                     len    <= rx_data;
                     idx    <= '0;
                     sum    <= '0;
                     w_addr <= '0;
                     state  <= DATA;
                  end
               end
               DATA: begin
                  if (rx_valid) begin
                     w_data <= rx_data;
                     we     <= 1'b1;
                     sum    <= sum + rx_data;
                     idx    <= idx + 8'd1;
                     if (idx == len) begin
`ifdef LOADER_CHECKSUM_EN
                        state <= CSUM;
`else
                        state <= FIN;
`endif
                     end
                  end
               end
               CSUM: begin
`ifdef LOADER_CHECKSUM_EN
                  if (rx_valid) begin
                     if (rx_data == frame_csum(len, sum)) begin
                        state <= FIN;
                     end else begin
                        err      <= 1'b1;
                        cpu_hold <= 1'b0;
                        state    <= IDLE;
                     end
                  end
`else
                  state <= IDLE;
`endif
               end
               FIN: begin
                  done     <= 1'b1;
                  cpu_hold <= 1'b0;
                  state    <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   assign ram.we     = we;
   assign ram.w_addr = w_addr;
   assign ram.w_data = w_data;

endmodule
